rank_drain: RTL and testbench
=============================

// Module: rank_drain
// PURPOSE
// - Consumer end of the rank pipe output interface (valid_out/remove/rank_out/meta_out).
// - Pops computed (rank, meta) pairs and buffers them in a 2-entry skid FIFO.
// - Presents them to the PIFO insert interface (insert/busy); insert only when busy==0.
// - Clamps ranks above a limit, gates draining with an enable, keeps insert/stall statistics.
// PARAMETERS
// - RANK_WIDTH   16           rank field width
// - META_WIDTH   16           metadata field width
// - RANK_MAX     16'hFFFE     largest rank forwarded; larger ranks are clamped to it
// - CNT_WIDTH    32           width of the statistics counters
// PORTS
// - clk            in   1           single clock
// - rstn           in   1           asynchronous, active-low reset
// - enable         in   1           1 = drain rank pipe; 0 = stop popping, flush held entries
// - rp_valid_out   in   1           rank pipe has a word available
// - rp_rank_out    in   RANK_WIDTH  rank from rank pipe
// - rp_meta_out    in   META_WIDTH  meta from rank pipe
// - rp_remove      out  1           pop strobe to rank pipe (combinational)
// - pifo_busy      in   1           PIFO cannot accept this cycle
// - pifo_insert    out  1           insert strobe to PIFO (combinational)
// - pifo_rank      out  RANK_WIDTH  rank to PIFO (buffer head)
// - pifo_meta      out  META_WIDTH  meta to PIFO (buffer head)
// - idle           out  1           state==IDLE and buffer empty
// - clamp_seen     out  1           sticky: a rank was clamped since reset
// - insert_count   out  CNT_WIDTH   PIFO inserts since reset, wraps
// - stall_count    out  CNT_WIDTH   cycles head held by pifo_busy, saturates
// BEHAVIOUR
// - Reset (rstn=0, async): buffer empty, state IDLE, all counters 0, clamp_seen 0;
//   rp_remove=0, pifo_insert=0, pifo_rank/meta=0, idle=1.
// - FSM: IDLE -> RUN when enable=1. RUN -> DRAIN when enable=0.
//   DRAIN -> IDLE when buffer empty; DRAIN -> RUN if enable returns to 1.
// - rp_remove = (state==RUN) & rp_valid_out & (count<2 | pifo_insert).
//   Never popped in IDLE/DRAIN; never asserted while rp_valid_out=0.
// - On rp_remove, word is written into buffer at next edge.
//   Stored rank = min(rp_rank_out, RANK_MAX); clamp_seen set if rp_rank_out>RANK_MAX.
// - pifo_insert = (count!=0) & ~pifo_busy; head pops on same edge.
// - Latency: word popped at edge N is on pifo_* during cycle N+1; with busy=0 it is
//   inserted in N+1. Sustained throughput 1 word/cycle.
// - Simultaneous pop + push with count==2: legal; count stays 2; order preserved (FIFO).
// - Push with count==0 and busy=0: word lands in head; inserted next cycle, no bypass.
// - pifo_rank/meta are 0 when buffer empty.
// - Counters: insert_count += pifo_insert, wraps at 2^CNT_WIDTH.
//   stall_count += (count!=0 & pifo_busy), saturates at all-ones.
// - Reset mid-operation discards buffered words; rank pipe words not yet popped are untouched.
// - enable deassert mid-burst: no new pops from the next cycle; buffered words still insert.
// STRUCTURE
// - Shared package: RANK_WIDTH/META_WIDTH defaults; state encoding
//   (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2); rank/meta entry typedef.
// - One sub-module: rank_drain_skid (2-entry FIFO; push/pop/count/head).
// - Top holds FSM, clamp, counters, handshake glue.
// TESTING
// - Reset then enable=1, one word rank=5 meta=0xAB, busy=0:
//   rp_remove 1 cycle; pifo_insert next cycle with 5/0xAB; insert_count=1.
// - Back-to-back 8 words, busy=0:
//   8 consecutive inserts, order preserved; rp_remove held 8 cycles; stall_count=0.
// - 3 words queued, busy=1 for 4 cycles:
//   2 popped, rp_remove low while full; stall_count=4; then 3 ordered inserts.
// - Rank 0xFFFF in, RANK_MAX=0xFFFE:
//   pifo_rank=0xFFFE, clamp_seen=1 and stays 1.
// - Buffer full, enable->0:
//   no further rp_remove; 2 inserts; DRAIN->IDLE; idle=1.
// - rstn low mid-burst with 2 buffered:
//   outputs 0 immediately (async); after release, insert_count=0, no stale inserts.

Source files
------------

// File: rtl/rank_drain_pkg.sv
// Shared widths, FSM state encoding and buffered entry layout for the rank pipe drain.
package rank_drain_pkg;

   localparam int DEF_RANK_WIDTH = 16;
   localparam int DEF_META_WIDTH = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic [DEF_RANK_WIDTH-1:0] rank;
      logic [DEF_META_WIDTH-1:0] meta;
   } entry_t;

endpackage

// File: rtl/rank_drain_skid.sv
// Two-entry FIFO between rank pipe and PIFO; head registered, zero when empty.
// Push and pop may coincide at any fill level, including full, without reordering.
module rank_drain_skid #(
   parameter int DW = 32
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          push_i,
   input  logic [DW-1:0] push_dat_i,
   input  logic          pop_i,
   output logic [1:0]    count_o,
   output logic [DW-1:0] head_o
);

   logic [DW-1:0] ent0_q, ent0_d;
   logic [DW-1:0] ent1_q, ent1_d;
   logic [1:0]    count_q, count_d;

   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10: begin
            if (count_q == 2'd0) begin
               ent0_d  = push_dat_i;
               count_d = 2'd1;
            end else if (count_q == 2'd1) begin
               ent1_d  = push_dat_i;
               count_d = 2'd2;
            end
         end
         2'b01: begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Entry at the head leaves this edge; incoming word goes behind what remains.
            if (count_q == 2'd1) begin
               ent0_d = push_dat_i;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_dat_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = (count_q != 2'd0) ? ent0_q : '0;

endmodule

// File: rtl/rank_drain.sv
// Drains (rank, meta) words from the rank pipe into the PIFO through a 2-entry skid buffer.
// One cycle pop-to-insert latency, 1 word/cycle sustained; pops stop when full and PIFO busy.
module rank_drain
   import rank_drain_pkg::*;
#(
   parameter int                    RANK_WIDTH = DEF_RANK_WIDTH,
   parameter int                    META_WIDTH = DEF_META_WIDTH,
   parameter logic [RANK_WIDTH-1:0] RANK_MAX   = {{(RANK_WIDTH-1){1'b1}}, 1'b0},
   parameter int                    CNT_WIDTH  = 32
)(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic                  rp_valid_out,
   input  logic [RANK_WIDTH-1:0] rp_rank_out,
   input  logic [META_WIDTH-1:0] rp_meta_out,
   output logic                  rp_remove,
   input  logic                  pifo_busy,
   output logic                  pifo_insert,
   output logic [RANK_WIDTH-1:0] pifo_rank,
   output logic [META_WIDTH-1:0] pifo_meta,
   output logic                  idle,
   output logic                  clamp_seen,
   output logic [CNT_WIDTH-1:0]  insert_count,
   output logic [CNT_WIDTH-1:0]  stall_count
);

   localparam int DW = RANK_WIDTH + META_WIDTH;

   logic [1:0]            state_q, state_d;
   logic [1:0]            count;
   logic [DW-1:0]         head;
   logic                  rank_over;
   logic [RANK_WIDTH-1:0] rank_clamped;
   logic                  clamp_q;
   logic [CNT_WIDTH-1:0]  ins_cnt_q;
   logic [CNT_WIDTH-1:0]  stall_cnt_q;

   assign rank_over    = rp_rank_out > RANK_MAX;
   assign rank_clamped = rank_over ? RANK_MAX : rp_rank_out;

   assign pifo_insert = (count != 2'd0) & ~pifo_busy;
   // A full buffer still accepts a word when its head leaves on the same edge.
   assign rp_remove   = (state_q == ST_RUN) & rp_valid_out &
                        ((count != 2'd2) | pifo_insert);

   rank_drain_skid #(.DW(DW)) u_skid (
      .clk        (clk),
      .rstn       (rstn),
      .push_i     (rp_remove),
      .push_dat_i ({rank_clamped, rp_meta_out}),
      .pop_i      (pifo_insert),
      .count_o    (count),
      .head_o     (head)
   );

   assign {pifo_rank, pifo_meta} = head;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)              state_d = ST_RUN;
            else if (count == 2'd0)  state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         clamp_q     <= 1'b0;
         ins_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (rp_remove && rank_over) clamp_q <= 1'b1;
         if (pifo_insert) ins_cnt_q <= ins_cnt_q + 1'b1;
         if ((count != 2'd0) && pifo_busy && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign idle         = (state_q == ST_IDLE) & (count == 2'd0);
   assign clamp_seen   = clamp_q;
   assign insert_count = ins_cnt_q;
   assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_rank_drain.sv
// Directed bench: rank pipe modelled as a word queue, PIFO inserts collected and checked.
module tb_rank_drain;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic        rp_valid_out;
   logic [15:0] rp_rank_out;
   logic [15:0] rp_meta_out;
   logic        rp_remove;
   logic        pifo_busy;
   logic        pifo_insert;
   logic [15:0] pifo_rank;
   logic [15:0] pifo_meta;
   logic        idle;
   logic        clamp_seen;
   logic [31:0] insert_count;
   logic [31:0] stall_count;

   rank_drain #(
      .RANK_WIDTH (16),
      .META_WIDTH (16),
      .RANK_MAX   (16'hFFFE),
      .CNT_WIDTH  (32)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .enable       (enable),
      .rp_valid_out (rp_valid_out),
      .rp_rank_out  (rp_rank_out),
      .rp_meta_out  (rp_meta_out),
      .rp_remove    (rp_remove),
      .pifo_busy    (pifo_busy),
      .pifo_insert  (pifo_insert),
      .pifo_rank    (pifo_rank),
      .pifo_meta    (pifo_meta),
      .idle         (idle),
      .clamp_seen   (clamp_seen),
      .insert_count (insert_count),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] r;
      logic [15:0] m;
      int          cyc;
   } rec_t;

   typedef struct {
      logic [15:0] rank;
      logic [15:0] meta;
      logic [15:0] exp_rank;
      logic [15:0] exp_meta;
      logic        exp_clamp;
   } vec_t;

   rec_t        got_q[$];
   logic [31:0] pipe_q[$];
   int          rem_cyc_q[$];
   int          cyc;
   int          n_tests;
   int          n_fail;
   vec_t        vt[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_pipe();
      if (pipe_q.size() > 0) begin
         rp_valid_out = 1'b1;
         {rp_rank_out, rp_meta_out} = pipe_q[0];
      end else begin
         rp_valid_out = 1'b0;
         rp_rank_out  = 16'h0;
         rp_meta_out  = 16'h0;
      end
   endtask

   // One clock: observe strobes mid-cycle, then present the next rank pipe word.
   task automatic tick();
      rec_t g;
      @(negedge clk);
      if (pifo_insert) begin
         g.r   = pifo_rank;
         g.m   = pifo_meta;
         g.cyc = cyc;
         got_q.push_back(g);
      end
      if (rp_remove) begin
         rem_cyc_q.push_back(cyc);
         if (pipe_q.size() > 0) void'(pipe_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_pipe();
   endtask

   task automatic wait_got(input int n, input int budget, input string name);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk({name, "_insert_cnt"}, got_q.size(), n);
   endtask

   task automatic clear_logs();
      got_q.delete();
      rem_cyc_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      vt[0] = '{16'd5,    16'h00AB, 16'd5,    16'h00AB, 1'b0};
      vt[1] = '{16'd0,    16'h0000, 16'd0,    16'h0000, 1'b0};
      vt[2] = '{16'hFFFE, 16'h1234, 16'hFFFE, 16'h1234, 1'b0};
      vt[3] = '{16'hFFFF, 16'hBEEF, 16'hFFFE, 16'hBEEF, 1'b1};
      vt[4] = '{16'd7,    16'h0055, 16'd7,    16'h0055, 1'b1};

      rstn      = 1'b0;
      enable    = 1'b0;
      pifo_busy = 1'b0;
      drive_pipe();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rp_remove",    rp_remove,    0);
      chk("rst_pifo_insert",  pifo_insert,  0);
      chk("rst_pifo_rank",    pifo_rank,    0);
      chk("rst_pifo_meta",    pifo_meta,    0);
      chk("rst_idle",         idle,         1);
      chk("rst_clamp_seen",   clamp_seen,   0);
      chk("rst_insert_count", insert_count, 0);
      chk("rst_stall_count",  stall_count,  0);
      rstn = 1'b1;
      tick();
      chk("idle_while_disabled", idle, 1);

      // Single words through the pipe, one at a time.
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         clear_logs();
         pipe_q.push_back({vt[i].rank, vt[i].meta});
         drive_pipe();
         wait_got(1, 10, $sformatf("vec%0d", i));
         if (got_q.size() == 1 && rem_cyc_q.size() == 1) begin
            chk($sformatf("vec%0d_rank", i), got_q[0].r, vt[i].exp_rank);
            chk($sformatf("vec%0d_meta", i), got_q[0].m, vt[i].exp_meta);
            chk($sformatf("vec%0d_latency", i), got_q[0].cyc - rem_cyc_q[0], 1);
         end
         chk($sformatf("vec%0d_pops", i), rem_cyc_q.size(), 1);
         chk($sformatf("vec%0d_clamp_seen", i), clamp_seen, vt[i].exp_clamp);
         chk($sformatf("vec%0d_insert_count", i), insert_count, i + 1);
      end

      // Back-to-back burst of 8 words with the PIFO always ready.
      clear_logs();
      for (int i = 0; i < 8; i++) pipe_q.push_back({16'h0100 + 16'(i), 16'h00C0 + 16'(i)});
      drive_pipe();
      wait_got(8, 30, "burst");
      for (int i = 0; i < got_q.size(); i++) begin
         chk($sformatf("burst%0d_rank", i), got_q[i].r, 16'h0100 + 16'(i));
         chk($sformatf("burst%0d_meta", i), got_q[i].m, 16'h00C0 + 16'(i));
      end
      if (got_q.size() == 8) chk("burst_insert_span", got_q[7].cyc - got_q[0].cyc, 7);
      chk("burst_pops", rem_cyc_q.size(), 8);
      if (rem_cyc_q.size() == 8) chk("burst_pop_span", rem_cyc_q[7] - rem_cyc_q[0], 7);
      chk("burst_stall_count",  stall_count,  0);
      chk("burst_insert_count", insert_count, 13);

      // Three words queued while the PIFO is busy for 4 cycles with data held.
      clear_logs();
      pifo_busy = 1'b1;
      for (int i = 0; i < 3; i++) pipe_q.push_back({16'h0200 + 16'(i), 16'h00D0 + 16'(i)});
      drive_pipe();
      tick();
      repeat (4) tick();
      chk("busy_stall_count", stall_count, 4);
      chk("busy_full_no_pop", rp_remove, 0);
      chk("busy_pops", rem_cyc_q.size(), 2);
      chk("busy_no_insert", got_q.size(), 0);
      chk("busy_pipe_left", pipe_q.size(), 1);
      pifo_busy = 1'b0;
      wait_got(3, 10, "busy");
      for (int i = 0; i < got_q.size(); i++)
         chk($sformatf("busy%0d_rank", i), got_q[i].r, 16'h0200 + 16'(i));
      chk("busy_insert_count", insert_count, 16);

      // Fill the buffer, drop enable, let the held words drain to IDLE.
      clear_logs();
      pifo_busy = 1'b1;
      for (int i = 0; i < 4; i++) pipe_q.push_back({16'h0300 + 16'(i), 16'h00E0 + 16'(i)});
      drive_pipe();
      repeat (3) tick();
      chk("drain_full_no_pop", rp_remove, 0);
      enable = 1'b0;
      tick();
      pifo_busy = 1'b0;
      k = 0;
      while (!idle && k < 10) begin
         tick();
         k++;
      end
      chk("drain_idle", idle, 1);
      chk("drain_inserts", got_q.size(), 2);
      for (int i = 0; i < got_q.size(); i++)
         chk($sformatf("drain%0d_rank", i), got_q[i].r, 16'h0300 + 16'(i));
      chk("drain_pops", rem_cyc_q.size(), 2);
      chk("drain_pipe_left", pipe_q.size(), 2);
      chk("drain_insert_count", insert_count, 18);
      chk("clamp_sticky", clamp_seen, 1);

      // Asynchronous reset with two words buffered.
      clear_logs();
      pifo_busy = 1'b1;
      enable    = 1'b1;
      repeat (3) tick();
      chk("prerst_pops", rem_cyc_q.size(), 2);
      pipe_q.push_back({16'h0777, 16'h0F0F});
      drive_pipe();
      pifo_busy = 1'b0;
      rstn      = 1'b0;
      #1;
      chk("arst_pifo_insert",  pifo_insert,  0);
      chk("arst_pifo_rank",    pifo_rank,    0);
      chk("arst_pifo_meta",    pifo_meta,    0);
      chk("arst_rp_remove",    rp_remove,    0);
      chk("arst_idle",         idle,         1);
      chk("arst_insert_count", insert_count, 0);
      chk("arst_stall_count",  stall_count,  0);
      chk("arst_clamp_seen",   clamp_seen,   0);
      enable = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      repeat (3) tick();
      chk("postrst_no_stale", got_q.size(), 0);
      chk("postrst_insert_count", insert_count, 0);
      chk("postrst_pipe_kept", pipe_q.size(), 1);
      enable = 1'b1;
      wait_got(1, 10, "postrst");
      if (got_q.size() == 1) begin
         chk("postrst_rank", got_q[0].r, 16'h0777);
         chk("postrst_meta", got_q[0].m, 16'h0F0F);
      end
      chk("postrst_insert_count_1", insert_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
